// File: rtl/gat_stage_scheduler.sv
// Top-level GAT sequencer: launches SPMM, DMVM, SM and AGGR in order for each
// layer, with a per-stage watchdog and a run-cycle counter.
module gat_stage_scheduler #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned LAYER_W    = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               spmm_rdy_i,
  input  logic               dmvm_rdy_i,
  input  logic               sm_rdy_i,
  input  logic               aggr_rdy_i,
  input  logic               spmm_vld_i,
  input  logic               dmvm_vld_i,
  input  logic               sm_vld_i,
  input  logic               aggr_vld_i,
  output logic               spmm_start_o,
  output logic               dmvm_start_o,
  output logic               sm_start_o,
  output logic               aggr_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_stage_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   total_cycles_o
);

  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [WDT_W-1:0]   WDT_LAST   = WDT_W'(WDT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SPMM_L = 4'd1,
    SPMM_W = 4'd2,
    DMVM_L = 4'd3,
    DMVM_W = 4'd4,
    SM_L   = 4'd5,
    SM_W   = 4'd6,
    AGGR_L = 4'd7,
    AGGR_W = 4'd8,
    DONE   = 4'd9,
    ERR    = 4'd10
  } state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               err_q, err_d;
  logic [1:0]         err_stage_q, err_stage_d;
  logic               busy_q, done_q;

  logic [3:0] rdy_v, vld_v, start_c;
  logic [1:0] stage_idx;
  logic       is_launch, is_wait;

  assign rdy_v = {aggr_rdy_i, sm_rdy_i, dmvm_rdy_i, spmm_rdy_i};
  assign vld_v = {aggr_vld_i, sm_vld_i, dmvm_vld_i, spmm_vld_i};

  // Launch states are odd codes 1..7, wait states the even codes 2..8
  assign is_launch = state_q inside {SPMM_L, DMVM_L, SM_L, AGGR_L};
  assign is_wait   = state_q inside {SPMM_W, DMVM_W, SM_W, AGGR_W};
  assign stage_idx = 2'((state_q - 4'd1) >> 1);

  // Next-state, counters and stage launch strobes
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    cyc_d       = cyc_q;
    wdt_d       = wdt_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    start_c     = '0;

    if ((is_launch || is_wait) && (cyc_q != '1)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          layer_d     = '0;
          cyc_d       = '0;
          err_stage_d = '0;
          state_d     = SPMM_L;
        end
      end
      DONE: state_d = IDLE;
      ERR:  state_d = ERR;
      default: begin
        if (is_launch) begin
          if (rdy_v[stage_idx]) begin
            start_c[stage_idx] = 1'b1;
            wdt_d              = '0;
            state_d            = state_e'(state_q + 4'd1);
          end
        end else if (is_wait) begin
          if (vld_v[stage_idx]) begin
            if (state_q == AGGR_W) begin
              if (layer_q == LAST_LAYER) begin
                state_d = DONE;
              end else begin
                layer_d = layer_q + LAYER_W'(1);
                state_d = SPMM_L;
              end
            end else begin
              state_d = state_e'(state_q + 4'd1);
            end
          end else if ((WDT_CYCLES != 0) && (wdt_q == WDT_LAST)) begin
            state_d     = ERR;
            err_d       = 1'b1;
            err_stage_d = stage_idx;
          end else begin
            wdt_d = wdt_q + WDT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // Abort wins over everything: no launch, progress and counters frozen
    if (abort_i) begin
      state_d     = IDLE;
      start_c     = '0;
      err_d       = 1'b0;
      layer_d     = layer_q;
      cyc_d       = cyc_q;
      wdt_d       = wdt_q;
      err_stage_d = err_stage_q;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      cyc_q       <= '0;
      wdt_q       <= '0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      cyc_q       <= cyc_d;
      wdt_q       <= wdt_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
      busy_q      <= !(state_d inside {IDLE, ERR});
      done_q      <= (state_d == DONE);
    end
  end

  assign spmm_start_o   = start_c[0];
  assign dmvm_start_o   = start_c[1];
  assign sm_start_o     = start_c[2];
  assign aggr_start_o   = start_c[3];
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign err_stage_o    = err_stage_q;
  assign layer_o        = layer_q;
  assign state_o        = state_q;
  assign total_cycles_o = cyc_q;

endmodule

// File: tb/tb_gat_stage_scheduler.sv
// Bench for gat_stage_scheduler: directed scenarios plus random traffic, all
// outputs compared each cycle against a stage/layer-level behavioural model.
module tb_gat_stage_scheduler;

  localparam int unsigned NL  = 2;
  localparam int unsigned LW  = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned WDT = 100;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [3:0] rdy = 4'h0;
  logic [3:0] vld = 4'h0;

  logic spmm_start, dmvm_start, sm_start, aggr_start;
  logic busy, done, err;
  logic [1:0] err_stage;
  logic [LW-1:0] layer;
  logic [3:0] state;
  logic [CW-1:0] total;

  int errors = 0;
  int checks = 0;

  gat_stage_scheduler #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .CNT_W(CW), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .spmm_rdy_i(rdy[0]), .dmvm_rdy_i(rdy[1]), .sm_rdy_i(rdy[2]), .aggr_rdy_i(rdy[3]),
    .spmm_vld_i(vld[0]), .dmvm_vld_i(vld[1]), .sm_vld_i(vld[2]), .aggr_vld_i(vld[3]),
    .spmm_start_o(spmm_start), .dmvm_start_o(dmvm_start),
    .sm_start_o(sm_start), .aggr_start_o(aggr_start),
    .busy_o(busy), .done_o(done), .err_o(err), .err_stage_o(err_stage),
    .layer_o(layer), .state_o(state), .total_cycles_o(total)
  );

  always #5 clk = ~clk;

  // Model: run phase, which stage, launched-or-waiting, cycles spent waiting
  typedef struct {
    int          mode;
    int          stage;
    logic        wt;
    int          wcnt;
    int          layer;
    logic        er;
    int          estage;
    logic [31:0] cy;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t model_next(input model_t c, input logic st, input logic ab,
                                        input logic [3:0] r, input logic [3:0] v);
    model_t n = c;
    if (ab) begin
      n.mode = M_IDLE;
      n.er   = 1'b0;
    end else begin
      case (c.mode)
        M_IDLE: if (st) begin
          n.mode = M_RUN; n.stage = 0; n.wt = 1'b0;
          n.layer = 0; n.cy = 0; n.estage = 0;
        end
        M_RUN: begin
          if (c.cy != 32'hFFFF_FFFF) n.cy = c.cy + 1;
          if (!c.wt) begin
            if (r[c.stage]) begin n.wt = 1'b1; n.wcnt = 0; end
          end else if (v[c.stage]) begin
            n.wt = 1'b0;
            if (c.stage < 3) n.stage = c.stage + 1;
            else if (c.layer == NL - 1) n.mode = M_DONE;
            else begin n.layer = c.layer + 1; n.stage = 0; end
          end else begin
            n.wcnt = c.wcnt + 1;
            if (WDT != 0 && n.wcnt == WDT) begin
              n.mode = M_ERR; n.er = 1'b1; n.estage = c.stage;
            end
          end
        end
        M_DONE: n.mode = M_IDLE;
        default: n.mode = M_ERR;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, start, abort, rdy, vld);
  end

  function automatic int exp_state(input model_t c);
    case (c.mode)
      M_IDLE:  return 0;
      M_RUN:   return 1 + 2 * c.stage + int'(c.wt);
      M_DONE:  return 9;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] es;
    for (int s = 0; s < 4; s++)
      es[s] = rst_n && !abort && (m.mode == M_RUN) && !m.wt && (m.stage == s) && rdy[s];
    chk("start_vec", 32'({aggr_start, sm_start, dmvm_start, spmm_start}), 32'(es));
    chk("state", 32'(state), 32'(exp_state(m)));
    chk("busy", 32'(busy), 32'(m.mode == M_RUN || m.mode == M_DONE));
    chk("done", 32'(done), 32'(m.mode == M_DONE));
    chk("err", 32'(err), 32'(m.er));
    chk("err_stage", 32'(err_stage), 32'(m.estage));
    chk("layer", 32'(layer), 32'(m.layer));
    chk("total_cycles", total, m.cy);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stage responder: complete the stage the model is waiting on, if unmasked
  task automatic auto_in(input logic [3:0] rmask, input logic [3:0] vmask);
    rdy = rmask;
    vld = (m.mode == M_RUN && m.wt) ? (4'(4'b0001 << m.stage) & vmask) : 4'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1; rdy = 4'hF; vld = 4'h0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      auto_in(4'hF, 4'hF);
      tick();
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int w;

    // Reset state
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_total", total, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_layer", 32'(layer), 32'd0);

    // Minimum-latency two-layer run
    pulse_start();
    chk("spmm_first_launch", 32'(spmm_start), 32'd1);
    run_to_done(40, n);
    chk("min_latency", 32'(n + 1), 32'(8 * NL + 1));
    chk("min_total", total, 32'd16);
    chk("min_layer", 32'(layer), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("total_hold", total, 32'd16);

    // DMVM held not-ready for 50 cycles
    pulse_start();
    n = 0;
    while (!(m.mode == M_RUN && m.stage == 1 && !m.wt) && n < 20) begin
      auto_in(4'b1101, 4'hF); tick(); n++;
    end
    for (int i = 0; i < 50; i++) begin auto_in(4'b1101, 4'hF); tick(); end
    chk("dmvm_hold_state", 32'(state), 32'd3);
    chk("dmvm_hold_nostart", 32'(dmvm_start), 32'd0);
    chk("dmvm_hold_noerr", 32'(err), 32'd0);
    auto_in(4'hF, 4'hF);
    #1 chk("dmvm_launch", 32'(dmvm_start), 32'd1);
    run_to_done(40, n);

    // Watchdog on SM
    tick();
    pulse_start();
    n = 0; w = 0;
    while (m.mode != M_ERR && n < 400) begin
      auto_in(4'hF, 4'b1011); tick(); n++;
      if (state == 4'd6) w++;
    end
    chk("wdt_cycles_in_sm_w", 32'(w), 32'd100);
    chk("wdt_err", 32'(err), 32'd1);
    chk("wdt_err_stage", 32'(err_stage), 32'd2);
    chk("wdt_busy", 32'(busy), 32'd0);
    chk("wdt_state", 32'(state), 32'd10);
    pulse_start();
    chk("err_ignores_start", 32'(state), 32'd10);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_from_err_state", 32'(state), 32'd0);
    chk("abort_clears_err", 32'(err), 32'd0);

    // Same-cycle vld with start, and stray aggr vld
    pulse_start();
    rdy = 4'hF; vld = 4'b1001;
    #1 chk("spmm_launch_with_vld", 32'(spmm_start), 32'd1);
    tick();
    chk("vld_at_launch_ignored", 32'(state), 32'd2);
    vld = 4'b1000;
    tick();
    chk("stray_vld_ignored", 32'(state), 32'd2);
    run_to_done(40, n);
    chk("stretched_total", total, 32'd17);

    // Abort in layer 1 AGGR_W
    tick();
    pulse_start();
    n = 0;
    while (!(m.mode == M_RUN && m.layer == 1 && m.stage == 3 && m.wt) && n < 40) begin
      auto_in(4'hF, 4'hF); tick(); n++;
    end
    abort = 1'b1; vld = 4'h0;
    tick();
    abort = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_layer_hold", 32'(layer), 32'd1);
    pulse_start();
    chk("restart_layer", 32'(layer), 32'd0);
    chk("restart_state", 32'(state), 32'd1);

    // Reset during SM_W
    n = 0;
    while (!(m.mode == M_RUN && m.stage == 2 && m.wt) && n < 20) begin
      auto_in(4'hF, 4'hF); tick(); n++;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_total", total, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(state), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 10) == 0;
      abort = ($urandom % 100) == 0;
      for (int s = 0; s < 4; s++) begin
        rdy[s] = ($urandom % 4) != 0;
        vld[s] = ($urandom % 5) == 0;
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; rdy = 4'h0; vld = 4'h0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
